dma_xfer_ctrl: RTL
==================

Name: dma_xfer_ctrl

Overview:
- DMA burst controller that drives the `dma_req` / `data_transfer` interface checked by the downstream DMA protocol checker.
- On a rising edge of `go`, it raises `dma_req` in that same cycle.
- From the next cycle it holds `data_transfer` high for 1 to 256 consecutive cycles while stepping a word address.
- Sits between the channel register file (source of `go`, `len`, `base_addr`) and the bus datapath / protocol checker.

Parameters:
- ADDR_W, 32, width of `base_addr` and `addr`.
- STRIDE, 4, byte increment of `addr` per transferred word.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- go  input  1  start request level from the register file; only its rising edge matters.
- len  input  8  burst length; 0 encodes 256 words, N (1..255) encodes N words. Sampled at start.
- base_addr  input  ADDR_W  first word byte address. Sampled at start.
- abort  input  1  terminates an active burst after the current word.
- dma_req  output  1  start acknowledge, combinational in the start cycle.
- data_transfer  output  1  high during each word-transfer cycle.
- addr  output  ADDR_W  byte address of the current word.
- word_cnt  output  9  number of words transferred in the current/last burst (0..256).
- done  output  1  one-cycle pulse when a burst ends.
- aborted  output  1  sticky; burst ended by `abort`. Cleared at the next start.
- ovr_err  output  1  sticky; a `go` rising edge occurred while not IDLE. Cleared at the next start.

Behaviour:
- Reset (async assert, sync release): state=IDLE, go_q=0, all outputs 0, addr=0, word_cnt=0.
- go_q is `go` registered every cycle. `go_rise = go & ~go_q`.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - `dma_req = go_rise` (combinational, same cycle as the edge); `data_transfer=0`.
  - On `go_rise`: latch `remaining = (len==0) ? 256 : len` (9 bits), latch `addr = base_addr`, clear `word_cnt`, `aborted`, `ovr_err`; go to XFER.
- XFER:
  - `data_transfer=1` every cycle, contiguous, never gapped; `dma_req=0`.
  - Each cycle: `word_cnt += 1`, `remaining -= 1`.
  - `addr += STRIDE` after each word; wraps modulo 2^ADDR_W, no error.
  - Normal end: when `remaining==1`, this is the last word; next state DONE.
  - `abort` high in an XFER cycle: that word completes and is the last one; set `aborted`; next state DONE. Minimum burst length is therefore 1 word.
  - `abort` coinciding with the last word: treated as a normal end; `aborted` stays 0.
- DONE: `done=1` for exactly one cycle; `data_transfer=0`; next state IDLE.
- Latency: `go` edge at cycle T → `dma_req` at T, `data_transfer` at T+1..T+L, `done` at T+L+1. Earliest next start is T+L+2.
- `go` rising edge in XFER or DONE: ignored, sets `ovr_err`. `go` held high produces no restart; a new falling then rising edge is required.
- `abort` in IDLE or DONE: ignored.
- `word_cnt` and `addr` hold their final values until the next start.
- Reset mid-burst: immediate return to IDLE, outputs to 0, no `done`.

Optional Feature:
- Macro DMA_XFER_SVA_EN.
- Defined: compiles in embedded concurrent assertions, all clocked on posedge clk and disabled iff `!reset_n`:
  - (a) `$rose(go)` in IDLE implies `dma_req`.
  - (b) `dma_req |=> data_transfer[*1:256]`.
  - (c) `done` implies `word_cnt == latched length` unless `aborted`.
  - (d) `done` is never high two cycles in a row.
  - (e) `data_transfer` and `dma_req` are never high together.
  - Cover points: length 1, length 256, abort.
- Undefined: no assertions or covers; synthesizable logic identical.

Test Plan:
- len=8'd4, base_addr=0x1000, go rise at T → `dma_req`=1 at T; `data_transfer` T+1..T+4 with addr 0x1000, 0x1004, 0x1008, 0x100C; `done` at T+5; word_cnt=4.
- len=0, go rise → exactly 256 contiguous `data_transfer` cycles; word_cnt=256; last addr = base+1020; `done` once.
- len=8'd10, abort high in the 3rd transfer cycle → 3 transfer cycles; `aborted`=1; word_cnt=3; `done` the following cycle.
- len=8'd5, go toggled low then high during XFER → burst unaffected (5 words); `ovr_err`=1; new start clears it.
- len=8'd1, base_addr=0xFFFFFFFC, then len=8'd2 with same base → first: single word, `done` at T+2; second: addr 0xFFFFFFFC then 0x00000000 (wrap).
- reset_n low in 3rd transfer cycle of len=20 → outputs 0 immediately, no `done`; go rise after release starts a fresh burst with word_cnt from 0.

Source files
------------

// File: rtl/dma_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// dma_xfer_ctrl
//
// DMA burst controller. A rising edge of `go` in IDLE is acknowledged
// combinationally on `dma_req`, then `data_transfer` is held high for the
// burst length (1..256 words) while `addr` steps by STRIDE bytes per word.
// A one-cycle `done` pulse closes every burst, whether it ended normally or
// was cut short by `abort`.
//
// Parameters:
//   ADDR_W         width of base_addr / addr
//   STRIDE         byte increment of addr per word
//
// Ports:
//   clk            system clock, posedge
//   reset_n        asynchronous active-low reset
//   go             start request level (rising edge starts a burst)
//   len            burst length, 0 encodes 256 words
//   base_addr      byte address of the first word
//   abort          end the active burst after the current word
//   dma_req        start acknowledge (combinational in the start cycle)
//   data_transfer  high in each word-transfer cycle
//   addr           byte address of the current word
//   word_cnt       words transferred in the current/last burst
//   done           one-cycle pulse at the end of a burst
//   aborted        sticky: last burst ended by abort
//   ovr_err        sticky: go rose while a burst was in progress
//
// Optional feature: define DMA_XFER_SVA_EN to compile in embedded protocol
// assertions and cover points (no effect on the synthesized logic).
// -----------------------------------------------------------------------------
module dma_xfer_ctrl #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned STRIDE = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              go,
   input  logic [7:0]        len,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              abort,
   output logic              dma_req,
   output logic              data_transfer,
   output logic [ADDR_W-1:0] addr,
   output logic [8:0]        word_cnt,
   output logic              done,
   output logic              aborted,
   output logic              ovr_err
);

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   state_e              state_q, state_d;
   logic                go_q;
   logic [8:0]          remaining_q, remaining_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [8:0]          word_cnt_q, word_cnt_d;
   logic                aborted_q, aborted_d;
   logic                ovr_err_q, ovr_err_d;
   logic                go_rise;

   assign go_rise = go & ~go_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         go_q        <= 1'b0;
         remaining_q <= '0;
         addr_q      <= '0;
         word_cnt_q  <= '0;
         aborted_q   <= 1'b0;
         ovr_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         go_q        <= go;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         word_cnt_q  <= word_cnt_d;
         aborted_q   <= aborted_d;
         ovr_err_q   <= ovr_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      addr_d        = addr_q;
      word_cnt_d    = word_cnt_q;
      aborted_d     = aborted_q;
      ovr_err_d     = ovr_err_q;
      dma_req       = 1'b0;
      data_transfer = 1'b0;
      done          = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Gate with reset so the acknowledge cannot leak out while held in reset.
            dma_req = go_rise & reset_n;
            if (go_rise) begin
               remaining_d = (len == 8'd0) ? 9'd256 : {1'b0, len};
               addr_d      = base_addr;
               word_cnt_d  = '0;
               aborted_d   = 1'b0;
               ovr_err_d   = 1'b0;
               state_d     = StXfer;
            end
         end
         StXfer: begin
            data_transfer = 1'b1;
            word_cnt_d    = word_cnt_q + 9'd1;
            remaining_d   = remaining_q - 9'd1;
            if (go_rise) begin
               ovr_err_d = 1'b1;
            end
            // A natural last word takes priority: abort on it is not an abort.
            if (remaining_q == 9'd1) begin
               state_d = StDone;
            end else if (abort) begin
               aborted_d = 1'b1;
               state_d   = StDone;
            end else begin
               // Only advance while more words follow, so addr holds the last word.
               addr_d = addr_q + ADDR_W'(STRIDE);
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
            if (go_rise) begin
               ovr_err_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign addr     = addr_q;
   assign word_cnt = word_cnt_q;
   assign aborted  = aborted_q;
   assign ovr_err  = ovr_err_q;

`ifdef DMA_XFER_SVA_EN
   // Burst length as decoded at start, kept for the done-count check.
   logic [8:0] len_lat_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_lat_q <= '0;
      end else if (dma_req) begin
         len_lat_q <= (len == 8'd0) ? 9'd256 : {1'b0, len};
      end
   end

   a_rise_req : assert property (@(posedge clk) disable iff (!reset_n)
      ($rose(go) && state_q == StIdle) |-> dma_req);
   a_req_xfer : assert property (@(posedge clk) disable iff (!reset_n)
      dma_req |=> data_transfer [*1:256]);
   a_done_cnt : assert property (@(posedge clk) disable iff (!reset_n)
      (done && !aborted) |-> (word_cnt == len_lat_q));
   a_done_one : assert property (@(posedge clk) disable iff (!reset_n)
      done |=> !done);
   a_excl     : assert property (@(posedge clk) disable iff (!reset_n)
      !(data_transfer && dma_req));

   c_len_1    : cover property (@(posedge clk) disable iff (!reset_n)
      done && !aborted && word_cnt == 9'd1);
   c_len_256  : cover property (@(posedge clk) disable iff (!reset_n)
      done && !aborted && word_cnt == 9'd256);
   c_abort    : cover property (@(posedge clk) disable iff (!reset_n)
      done && aborted);
`endif

endmodule
